draw_card_grid: RTL and testbench

- Draws a ROWS x COLS grid of memory-game cards onto the VGA bus in one block, replacing per-card instances.
- Holds a double-buffered card state table. The game FSM writes entries one at a time into a shadow copy, then requests a commit. The commit is applied at the next vertical-blank start, so a frame never shows a half-updated board.
- Sits in the VGA chain between the background/board drawer and the mouse/text overlays.

---
 rtl/draw_card_grid_if.sv | 13 +
 rtl/draw_card_grid.sv | 211 +++++++++++++++++++++
 tb/tb_draw_card_grid.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/draw_card_grid_if.sv
// VGA pixel bus carried between drawing stages: sync, blanking, raster position and colour.
interface draw_card_grid_if;
    logic        hs;
    logic        vs;
    logic        hblnk;
    logic        vblnk;
    logic [11:0] hcount;
    logic [11:0] vcount;
    logic [11:0] rgb;

    modport master (output hs, vs, hblnk, vblnk, hcount, vcount, rgb);
    modport slave  (input  hs, vs, hblnk, vblnk, hcount, vcount, rgb);
endinterface

// File: rtl/draw_card_grid.sv
// Draws a ROWS x COLS grid of memory-game cards from a double-buffered state table, 2-cycle latency.
// Optional selection border around one card when CARD_GRID_CURSOR_EN is defined.
module draw_card_grid #(
    parameter int unsigned X_POS         = 50,
    parameter int unsigned Y_POS         = 50,
    parameter int unsigned CARD_W        = 100,
    parameter int unsigned CARD_H        = 140,
    parameter int unsigned GAP           = 20,
    parameter int unsigned COLS          = 4,
    parameter int unsigned ROWS          = 4,
    parameter int unsigned ADDR_W        = 4,
    parameter logic [11:0] COVERED_COLOR = 12'h0_A_A
`ifdef CARD_GRID_CURSOR_EN
    ,
    parameter int unsigned BORDER        = 4,
    parameter logic [11:0] CURSOR_COLOR  = 12'hF_F_0
`endif
) (
    input  logic                  pclk,
    input  logic                  rst,
    draw_card_grid_if.slave       vga_in,
    draw_card_grid_if.master      vga_out,
    input  logic                  card_wr,
    input  logic [ADDR_W-1:0]     card_addr,
    input  logic [13:0]           card_data,
    input  logic                  commit_req,
    output logic                  commit_busy,
    output logic                  commit_done
`ifdef CARD_GRID_CURSOR_EN
    ,
    input  logic                  cursor_en,
    input  logic [ADDR_W-1:0]     cursor_idx
`endif
);

    localparam int unsigned NCARDS  = ROWS * COLS;
    localparam int unsigned IDX_W   = (NCARDS > 1) ? $clog2(NCARDS) : 1;
    localparam int unsigned PITCH_X = CARD_W + GAP;
    localparam int unsigned PITCH_Y = CARD_H + GAP;

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        hblnk;
        logic        vblnk;
        logic [11:0] hcount;
        logic [11:0] vcount;
        logic [11:0] rgb;
    } vga_t;

    typedef enum logic {
        COMMIT_IDLE,
        COMMIT_PENDING
    } commit_state_t;

    commit_state_t state_q, state_d;
    logic          vblnk_prev_q, vblnk_prev_d;
    logic          commit_done_q, commit_done_d;
    logic [13:0]   shadow_q [NCARDS];
    logic [13:0]   shadow_d [NCARDS];
    logic [13:0]   active_q [NCARDS];
    logic [13:0]   active_d [NCARDS];
    logic          vblnk_rise;
    logic          apply;

    vga_t             bus_in;
    vga_t             s1_q, s1_d;
    vga_t             s2_q, s2_d;
    logic             hit_q, hit_d;
    logic [IDX_W-1:0] col_q, col_d;
    logic [IDX_W-1:0] row_q, row_d;
    logic             col_hit, row_hit;
    logic [11:0]      x_lo, y_lo;
    logic [IDX_W-1:0] sel_idx;
    logic [13:0]      card_sel;
`ifdef CARD_GRID_CURSOR_EN
    logic             border_q, border_d;
    logic             col_edge, row_edge;
`endif

    assign bus_in = {vga_in.hs, vga_in.vs, vga_in.hblnk, vga_in.vblnk,
                     vga_in.hcount, vga_in.vcount, vga_in.rgb};

    // Commit control: a pending request (or one arriving on the edge cycle itself)
    // copies the shadow table on the vblank rising edge.
    assign vblnk_rise = vga_in.vblnk & ~vblnk_prev_q;
    assign apply      = vblnk_rise & ((state_q == COMMIT_PENDING) | commit_req);

    always_comb begin
        state_d       = state_q;
        vblnk_prev_d  = vga_in.vblnk;
        commit_done_d = apply;
        shadow_d      = shadow_q;
        active_d      = active_q;

        unique case (state_q)
            COMMIT_IDLE:    if (commit_req && !apply) state_d = COMMIT_PENDING;
            COMMIT_PENDING: if (apply)                state_d = COMMIT_IDLE;
            default:                                  state_d = COMMIT_IDLE;
        endcase

        if (apply) begin
            active_d = shadow_q;
        end
        if (card_wr && (32'(card_addr) < NCARDS)) begin
            shadow_d[card_addr[IDX_W-1:0]] = card_data;
        end
    end

    assign commit_busy = (state_q == COMMIT_PENDING);
    assign commit_done = commit_done_q;

    // Stage 1: per-column and per-row window compares on the raster position.
    always_comb begin
        s1_d    = bus_in;
        col_hit = 1'b0;
        row_hit = 1'b0;
        col_d   = '0;
        row_d   = '0;
        x_lo    = '0;
        y_lo    = '0;
`ifdef CARD_GRID_CURSOR_EN
        col_edge = 1'b0;
        row_edge = 1'b0;
`endif
        for (int unsigned c = 0; c < COLS; c++) begin
            x_lo = 12'(X_POS + c * PITCH_X);
            if (bus_in.hcount >= x_lo && bus_in.hcount < x_lo + 12'(CARD_W)) begin
                col_hit = 1'b1;
                col_d   = IDX_W'(c);
`ifdef CARD_GRID_CURSOR_EN
                col_edge = (bus_in.hcount < x_lo + 12'(BORDER)) ||
                           (bus_in.hcount >= x_lo + 12'(CARD_W - BORDER));
`endif
            end
        end
        for (int unsigned r = 0; r < ROWS; r++) begin
            y_lo = 12'(Y_POS + r * PITCH_Y);
            if (bus_in.vcount >= y_lo && bus_in.vcount < y_lo + 12'(CARD_H)) begin
                row_hit = 1'b1;
                row_d   = IDX_W'(r);
`ifdef CARD_GRID_CURSOR_EN
                row_edge = (bus_in.vcount < y_lo + 12'(BORDER)) ||
                           (bus_in.vcount >= y_lo + 12'(CARD_H - BORDER));
`endif
            end
        end
        hit_d = col_hit & row_hit;
`ifdef CARD_GRID_CURSOR_EN
        border_d = col_edge | row_edge;
`endif
    end

    // Stage 2: colour select from the active table (cursor border wins over card colour).
    assign sel_idx  = IDX_W'(32'(row_q) * COLS + 32'(col_q));
    assign card_sel = active_q[sel_idx];

    always_comb begin
        s2_d = s1_q;
        if (hit_q && card_sel[0]) begin
            s2_d.rgb = card_sel[1] ? card_sel[13:2] : COVERED_COLOR;
        end
`ifdef CARD_GRID_CURSOR_EN
        if (cursor_en && (32'(cursor_idx) < NCARDS) && hit_q && border_q &&
            (32'(cursor_idx) == 32'(sel_idx))) begin
            s2_d.rgb = CURSOR_COLOR;
        end
`endif
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            state_q       <= COMMIT_IDLE;
            vblnk_prev_q  <= 1'b0;
            commit_done_q <= 1'b0;
            shadow_q      <= '{default: '0};
            active_q      <= '{default: '0};
            s1_q          <= '0;
            s2_q          <= '0;
            hit_q         <= 1'b0;
            col_q         <= '0;
            row_q         <= '0;
`ifdef CARD_GRID_CURSOR_EN
            border_q      <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            vblnk_prev_q  <= vblnk_prev_d;
            commit_done_q <= commit_done_d;
            shadow_q      <= shadow_d;
            active_q      <= active_d;
            s1_q          <= s1_d;
            s2_q          <= s2_d;
            hit_q         <= hit_d;
            col_q         <= col_d;
            row_q         <= row_d;
`ifdef CARD_GRID_CURSOR_EN
            border_q      <= border_d;
`endif
        end
    end

    assign vga_out.hs     = s2_q.hs;
    assign vga_out.vs     = s2_q.vs;
    assign vga_out.hblnk  = s2_q.hblnk;
    assign vga_out.vblnk  = s2_q.vblnk;
    assign vga_out.hcount = s2_q.hcount;
    assign vga_out.vcount = s2_q.vcount;
    assign vga_out.rgb    = s2_q.rgb;

endmodule

// File: tb/tb_draw_card_grid.sv
// Bench for draw_card_grid: reference model from card geometry and commit rules, per-cycle compare.
// Cursor checks are built when CARD_GRID_CURSOR_EN is defined.
module tb_draw_card_grid;

    localparam int X    = 50;
    localparam int Y    = 50;
    localparam int W    = 100;
    localparam int H    = 140;
    localparam int G    = 20;
    localparam int COLS = 4;
    localparam int ROWS = 4;
    localparam int NC   = ROWS * COLS;
    localparam int PX   = W + G;
    localparam int PY   = H + G;
    localparam logic [11:0] COV = 12'h0AA;
`ifdef CARD_GRID_CURSOR_EN
    localparam int          BRD = 4;
    localparam logic [11:0] CUR = 12'hFF0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    draw_card_grid_if vin ();
    draw_card_grid_if vout ();

    logic        card_wr    = 1'b0;
    logic [4:0]  card_addr  = '0;
    logic [13:0] card_data  = '0;
    logic        commit_req = 1'b0;
    logic        commit_busy;
    logic        commit_done;
`ifdef CARD_GRID_CURSOR_EN
    logic        cursor_en  = 1'b0;
    logic [4:0]  cursor_idx = '0;
`endif

    int n_checks = 0;
    int n_err    = 0;

    draw_card_grid #(.ADDR_W(5)) dut (
        .pclk        (clk),
        .rst         (rst),
        .vga_in      (vin),
        .vga_out     (vout),
        .card_wr     (card_wr),
        .card_addr   (card_addr),
        .card_data   (card_data),
        .commit_req  (commit_req),
        .commit_busy (commit_busy),
        .commit_done (commit_done)
`ifdef CARD_GRID_CURSOR_EN
        ,
        .cursor_en   (cursor_en),
        .cursor_idx  (cursor_idx)
`endif
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model state
    logic [13:0] m_shadow [NC];
    logic [13:0] m_active [NC];
    bit          m_pend, m_vprev, m_valid, m_apply;
    logic [39:0] m_prev, m_cur, exp_bus;
    bit          exp_busy, exp_done;

    function automatic logic [11:0] render(input int h, input int v, input logic [11:0] rgb_in);
        int dx, dy, c, r, ox, oy, idx;
        bit hit;
        logic [11:0] res;
        logic [13:0] e;
        res = rgb_in;
        hit = 0;
        ox = 0; oy = 0; idx = 0;
        if (h >= X && v >= Y) begin
            dx = h - X; dy = v - Y;
            c = dx / PX; r = dy / PY;
            ox = dx % PX; oy = dy % PY;
            hit = (c < COLS) && (r < ROWS) && (ox < W) && (oy < H);
            idx = r * COLS + c;
        end
        if (hit) begin
            e = m_active[idx];
            if (e[0]) res = e[1] ? e[13:2] : COV;
        end
`ifdef CARD_GRID_CURSOR_EN
        if (hit && cursor_en && int'(cursor_idx) < NC && int'(cursor_idx) == idx &&
            (ox < BRD || ox >= W - BRD || oy < BRD || oy >= H - BRD))
            res = CUR;
`endif
        return res;
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            m_cur = {vin.hs, vin.vs, vin.hblnk, vin.vblnk, vin.hcount, vin.vcount, vin.rgb};
            if (rst) begin
                for (int k = 0; k < NC; k++) begin
                    m_shadow[k] = '0;
                    m_active[k] = '0;
                end
                m_pend = 0; m_vprev = 0; m_valid = 0;
                exp_bus = '0; exp_busy = 0; exp_done = 0;
            end else begin
                exp_bus = m_valid ? {m_prev[39:12], render(int'(m_prev[35:24]), int'(m_prev[23:12]), m_prev[11:0])}
                                  : 40'h0;
                m_apply = vin.vblnk && !m_vprev && (m_pend || commit_req);
                if (m_apply)
                    for (int k = 0; k < NC; k++) m_active[k] = m_shadow[k];
                m_pend = !m_apply && (m_pend || commit_req);
                if (card_wr && int'(card_addr) < NC) m_shadow[card_addr] = card_data;
                m_vprev  = vin.vblnk;
                m_prev   = m_cur;
                m_valid  = 1;
                exp_busy = m_pend;
                exp_done = m_apply;
            end
            #1;
            check("vga_out", {vout.hs, vout.vs, vout.hblnk, vout.vblnk, vout.hcount, vout.vcount, vout.rgb}, exp_bus);
            check("commit_busy", commit_busy, exp_busy);
            check("commit_done", commit_done, exp_done);
        end
    end

    task automatic rand_px();
        vin.hcount = 12'($urandom_range(0, 800));
        vin.vcount = 12'($urandom_range(0, 760));
        vin.rgb    = 12'($urandom);
        vin.hs     = 1'($urandom);
        vin.vs     = 1'($urandom);
        vin.hblnk  = 1'($urandom);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            rand_px();
        end
    endtask

    task automatic write_card(input int addr, input logic [13:0] data);
        @(negedge clk);
        rand_px();
        card_wr = 1'b1; card_addr = 5'(addr); card_data = data;
        @(negedge clk);
        card_wr = 1'b0;
        rand_px();
    endtask

    task automatic pulse_commit();
        @(negedge clk);
        rand_px();
        commit_req = 1'b1;
        @(negedge clk);
        commit_req = 1'b0;
        rand_px();
    endtask

    task automatic set_vblnk(input logic b);
        @(negedge clk);
        vin.vblnk = b;
        rand_px();
    endtask

    task automatic wait_done(input string name);
        int cnt;
        cnt = 0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (commit_done) cnt++;
        end
        check(name, cnt, 1);
    endtask

    task automatic check_px(input string name, input int h, input int v,
                            input logic [11:0] rgb, input logic [11:0] exp);
        @(negedge clk);
        vin.hcount = 12'(h); vin.vcount = 12'(v); vin.rgb = rgb;
        @(posedge clk);
        @(posedge clk);
        #1;
        check(name, vout.rgb, exp);
    endtask

    task automatic full_commit(input string name);
        set_vblnk(1'b0);
        pulse_commit();
        set_vblnk(1'b1);
        wait_done(name);
    endtask

    initial begin
        vin.hs = 0; vin.vs = 0; vin.hblnk = 0; vin.vblnk = 0;
        vin.hcount = '0; vin.vcount = '0; vin.rgb = '0;
        repeat (3) @(negedge clk);
        check("reset_rgb", vout.rgb, 12'h000);
        check("reset_busy", commit_busy, 1'b0);
        rst = 1'b0;

        // Empty table: everything passes through
        idle(2000);
        check_px("empty_card5", 170, 210, 12'h5A5, 12'h5A5);

        // Front card at index 5, commit requested mid-frame
        write_card(5, {12'hF00, 2'b11});
        pulse_commit();
        check("busy_set", commit_busy, 1'b1);
        idle(30);
        check("busy_hold", commit_busy, 1'b1);
        check_px("before_apply", 170, 210, 12'h321, 12'h321);
        set_vblnk(1'b1);
        wait_done("done_card5");
        check("busy_clear", commit_busy, 1'b0);
        check_px("card5_tl", 170, 210, 12'h321, 12'hF00);
        check_px("card5_br", 269, 349, 12'h321, 12'hF00);
        check_px("card5_right", 270, 210, 12'h321, 12'h321);
        check_px("card5_left", 169, 210, 12'h654, 12'h654);
        check_px("card5_below", 200, 350, 12'h654, 12'h654);

        // Back card at index 0: invisible until committed
        write_card(0, {12'h0F0, 2'b01});
        check_px("card0_uncommitted", 50, 50, 12'h123, 12'h123);
        full_commit("done_card0");
        check_px("card0_covered", 50, 50, 12'h777, COV);
        check_px("card0_edge", 149, 189, 12'h777, COV);
        check_px("gap_pass", 150, 50, 12'h456, 12'h456);

        // Out-of-range writes are dropped
        write_card(16, 14'h3FFF);
        write_card(31, 14'h3FFF);
        full_commit("done_oob");
        check_px("oob_card5", 200, 300, 12'h111, 12'hF00);
        check_px("oob_card15", 410, 530, 12'h222, 12'h222);

        // Write on the applying edge lands in shadow only
        set_vblnk(1'b0);
        write_card(3, {12'h00F, 2'b11});
        pulse_commit();
        @(negedge clk);
        rand_px();
        vin.vblnk = 1'b1;
        card_wr = 1'b1; card_addr = 5'd3; card_data = {12'h123, 2'b11};
        @(posedge clk);
        #1;
        check("race_done", commit_done, 1'b1);
        @(negedge clk);
        card_wr = 1'b0;
        check_px("race_old", 410, 50, 12'h999, 12'h00F);
        full_commit("done_race2");
        check_px("race_new", 410, 50, 12'h999, 12'h123);

        // Request on the edge cycle applies immediately; busy never rises
        write_card(15, {12'hABC, 2'b11});
        set_vblnk(1'b0);
        @(negedge clk);
        rand_px();
        commit_req = 1'b1;
        vin.vblnk  = 1'b1;
        @(negedge clk);
        commit_req = 1'b0;
        check("edge_req_done", commit_done, 1'b1);
        check("edge_req_busy", commit_busy, 1'b0);
        check_px("card15_front", 509, 669, 12'h000, 12'hABC);

`ifdef CARD_GRID_CURSOR_EN
        @(negedge clk);
        cursor_en = 1'b1; cursor_idx = 5'd0;
        check_px("cur_tl", 50, 50, 12'h010, CUR);
        check_px("cur_left", 53, 189, 12'h010, CUR);
        check_px("cur_inner", 60, 60, 12'h010, COV);
        check_px("cur_inner_x", 54, 100, 12'h010, COV);
        check_px("cur_right", 146, 100, 12'h010, CUR);
        check_px("cur_bottom", 100, 186, 12'h010, CUR);
        check_px("cur_above_b", 100, 185, 12'h010, COV);
        @(negedge clk);
        cursor_idx = 5'd16;
        check_px("cur_oob", 50, 50, 12'h010, COV);
        @(negedge clk);
        cursor_idx = 5'd14;
        check_px("cur_inactive", 290, 530, 12'h020, CUR);
        @(negedge clk);
        cursor_en = 1'b0;
        check_px("cur_off", 50, 50, 12'h010, COV);
`endif

        // Random traffic against the model
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            rand_px();
            card_wr    = ($urandom_range(0, 3) == 0);
            card_addr  = 5'($urandom_range(0, 31));
            card_data  = 14'($urandom);
            commit_req = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 39) == 0) vin.vblnk = ~vin.vblnk;
`ifdef CARD_GRID_CURSOR_EN
            if (i % 100 == 0) begin
                cursor_en  = 1'($urandom);
                cursor_idx = 5'($urandom_range(0, 17));
            end
`endif
        end
        @(negedge clk);
        card_wr = 1'b0; commit_req = 1'b0;
        idle(4);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", n_err, n_checks);
        $fatal(1, "watchdog");
    end

endmodule
